// File: rtl/d_latch_pkg.sv
// Shared defaults for the gated-SR D latch.
`timescale 1ns/1ps
package d_latch_pkg;

    localparam int   WIDTH_DEF   = 1;
    localparam logic RST_VAL_DEF = 1'b0;

endpackage

// File: rtl/sr_latch.sv
// Level-sensitive SR latch cell: S sets, R clears, neither holds.
`timescale 1ns/1ps
module sr_latch (
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_qn
);

    // NOTE: storage elements take non-blocking assignments, latches included.
    always_latch begin
        if (i_s) begin
            o_q <= 1'b1;
        end else if (i_r) begin
            o_q <= 1'b0;
        end
    end

    assign o_qn = ~o_q;

endmodule

// File: rtl/d_latch_with_sr.sv
// D latch, transparent while clk is high, with a reset that only acts in the high phase.
`timescale 1ns/1ps
module d_latch_with_sr
    import d_latch_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_VAL_DEF}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_q_bar
);

    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_rst;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Reset steers onto whichever SR input drives the bit to its reset value.
        if (RST_VAL[i]) begin : g_rst_hi
            assign w_set[i] = clk & (~reset | in_d[i]);
            assign w_rst[i] = clk & reset & ~in_d[i];
        end else begin : g_rst_lo
            assign w_set[i] = clk & reset & in_d[i];
            assign w_rst[i] = clk & (~reset | ~in_d[i]);
        end

        sr_latch u_sr (
            .i_s  (w_set[i]),
            .i_r  (w_rst[i]),
            .o_q  (out_q[i]),
            .o_qn (out_q_bar[i])
        );
    end

    always_comb begin
        assert ((w_set & w_rst) == '0)
            else $error("sr_latch driven with S=R=1: set=%b rst=%b", w_set, w_rst);
    end

endmodule

// File: tb/tb_d_latch_with_sr.sv
// Bench for d_latch_with_sr: directed phase scenarios plus randomized inputs against a rule-level model.
`timescale 1ns/1ps
module tb_d_latch_with_sr;

    localparam logic       RST1 = 1'b0;
    localparam logic [3:0] RST4 = 4'b1010;

    logic       clk;
    logic       rst_n;
    logic       d1;
    logic [3:0] d4;
    logic       q1;
    logic       qn1;
    logic [3:0] q4;
    logic [3:0] qn4;

    int n_checks = 0;
    int n_errors = 0;

    d_latch_with_sr dut1 (
        .clk       (clk),
        .reset     (rst_n),
        .in_d      (d1),
        .out_q     (q1),
        .out_q_bar (qn1)
    );

    d_latch_with_sr #(.WIDTH(4), .RST_VAL(RST4)) dut4 (
        .clk       (clk),
        .reset     (rst_n),
        .in_d      (d4),
        .out_q     (q4),
        .out_q_bar (qn4)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic at(input time t);
        if (t > $time) #(t - $time);
    endtask

    // Reference model: while clk is high the output is the reset value or the data,
    // while clk is low it is whatever the last high-phase sample produced.
    // Samples fall at t%5==2; stimulus only moves on multiples of 5.
    initial begin : compare
        logic       m1;
        logic [3:0] m4;
        bit         seen_high;
        seen_high = 1'b0;
        m1 = 1'b0;
        m4 = '0;
        #2;
        forever begin
            if (clk) begin
                seen_high = 1'b1;
                m1 = rst_n ? d1 : RST1;
                m4 = rst_n ? d4 : RST4;
            end
            if (seen_high) begin
                check("model_q1",  {31'd0, q1},  {31'd0, m1});
                check("model_qn1", {31'd0, qn1}, {31'd0, ~m1});
                check("model_q4",  {28'd0, q4},  {28'd0, m4});
                check("model_qn4", {28'd0, qn4}, {28'd0, ~m4});
            end
            #5;
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        d1    = 1'b0;
        d4    = 4'b0000;

        // Reset during the first high phase.
        at(78);
        check("rst_q",    {31'd0, q1},  32'd0);
        check("rst_qn",   {31'd0, qn1}, 32'd1);
        check("rst_q4",   {28'd0, q4},  32'ha);
        check("rst_qn4",  {28'd0, qn4}, 32'h5);

        // Transparent with d=0.
        at(110); rst_n = 1'b1;
        at(178);
        check("transp_d0", {31'd0, q1}, 32'd0);

        // Reset overrides d=1.
        at(210); d1 = 1'b1; rst_n = 1'b0;
        at(278);
        check("rst_over_d", {31'd0, q1}, 32'd0);
        check("rst_over_d4", {28'd0, q4}, 32'ha);

        // Transparent with d=1.
        at(310); rst_n = 1'b1; d4 = 4'b0110;
        at(358);
        check("transp_d1",  {31'd0, q1},  32'd1);
        check("transp_qn1", {31'd0, qn1}, 32'd0);
        check("transp_d4",  {28'd0, q4},  32'h6);

        // Mid-phase data change propagates at once, then is held after the fall.
        at(375); d1 = 1'b0;
        at(378);
        check("mid_d_change", {31'd0, q1}, 32'd0);
        at(418);
        check("hold_after_fall", {31'd0, q1}, 32'd0);

        // Low-phase activity on d and reset is ignored.
        at(420); d1 = 1'b1;
        at(425); rst_n = 1'b0;
        at(430); rst_n = 1'b1;
        at(448);
        check("hold_ignore_in",  {31'd0, q1},  32'd0);
        check("hold_ignore_qn",  {31'd0, qn1}, 32'd1);
        at(458);
        check("next_high_d1", {31'd0, q1}, 32'd1);

        // Reset asserted, then released, inside one high phase.
        at(465); rst_n = 1'b0;
        at(468);
        check("mid_rst_assert", {31'd0, q1}, 32'd0);
        at(475); rst_n = 1'b1;
        at(478);
        check("mid_rst_release", {31'd0, q1}, 32'd1);

        // Value before the fall at 500 is kept through the low phase.
        at(510); d1 = 1'b0;
        at(518);
        check("hold_one", {31'd0, q1}, 32'd1);
        at(568);
        check("follow_after_hold", {31'd0, q1}, 32'd0);

        // Randomized phase: changes on a 5 ns grid, never on a clock edge.
        for (int k = 6; k < 306; k++) begin
            for (int off = 5; off < 100; off += 5) begin
                if (off == 50) continue;
                at(time'(k * 100 + off));
                if ($urandom_range(0, 2) == 0) d1 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) d4 = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 5) == 0) rst_n = ~rst_n;
            end
        end

        at(30_690);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
